// File: rtl/i2c_pkg.sv
// Shared definitions for the APB master: FSM state encoding,
// default ACCESS timeout and wait-counter width.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int WAIT_W          = 8;

endpackage

// File: rtl/i2c_apb_master.sv
// Command-driven APB master: accepts one read/write command, runs the
// SETUP/ACCESS handshake with an ACCESS-phase timeout, returns a response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          command handshake
//   cmd_write/posted         direction; posted writes skip the response
//   cmd_addr/wdata           APB address and write data
//   rsp_valid/ready          response handshake
//   rsp_rdata/err            read data (0 for writes/timeouts), timeout flag
//   apb_*                    APB requester signals
//   busy                     high whenever the FSM is not IDLE
module i2c_apb_master
    import i2c_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_posted,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        apb_sel,
    output logic        apb_en,
    output logic        apb_write,
    output logic [31:0] apb_addr,
    output logic [31:0] apb_wdata,
    input  logic        apb_ready,
    input  logic [31:0] apb_rdata,
    output logic        busy
);

    // The counter holds the number of ACCESS cycles already spent waiting;
    // the cycle in which it equals TIMEOUT-1 is the last one allowed.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t state;
    state_t state_next;

    logic              write_q;
    logic              posted_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic accept;
    logic done;
    logic timeout;

    assign accept  = cmd_valid && (state == ST_IDLE);
    assign done    = (state == ST_ACCESS) && apb_ready;
    assign timeout = (state == ST_ACCESS) && !apb_ready
                     && (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_ready) begin
                    state_next = posted_q ? ST_IDLE : ST_RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        apb_sel   = 1'b0;
        apb_en    = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_SETUP: begin
                apb_sel = 1'b1;
            end
            ST_ACCESS: begin
                apb_sel = 1'b1;
                apb_en  = 1'b1;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= 1'b0;
            posted_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                write_q  <= cmd_write;
                // Posting only applies to writes.
                posted_q <= cmd_write && cmd_posted;
                addr_q   <= cmd_addr;
                wdata_q  <= cmd_wdata;
            end
            if (state == ST_SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ST_ACCESS) && !apb_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (done) begin
                rdata_q <= write_q ? 32'h0 : apb_rdata;
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end
        end
    end

    assign apb_write = write_q;
    assign apb_addr  = addr_q;
    assign apb_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_i2c_apb_master.sv
// Directed bench for i2c_apb_master: APB phase checks inline, responses
// checked against a queue of expected results by a handshake monitor.
module tb_i2c_apb_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_posted;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic [31:0] apb_addr;
    logic [31:0] apb_wdata;
    logic        apb_ready;
    logic [31:0] apb_rdata;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    i2c_apb_master #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_posted (cmd_posted),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb_sel    (apb_sel),
        .apb_en     (apb_en),
        .apb_write  (apb_write),
        .apb_addr   (apb_addr),
        .apb_wdata  (apb_wdata),
        .apb_ready  (apb_ready),
        .apb_rdata  (apb_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert (!(apb_en && !apb_sel)) else begin
                errors++;
                $error("FAIL en_without_sel observed=%b expected=0", apb_en);
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_rsp observed=%h expected=none",
                           rsp_rdata);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    assert ({rsp_rdata, rsp_err} === e) else begin
                        errors++;
                        $error("FAIL rsp observed=%h/%b expected=%h/%b",
                               rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_posted = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        rsp_ready  = 1'b1;
        apb_ready  = 1'b0;
        apb_rdata  = '0;

        // Reset values
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
        chk("rst_apb_write", 32'(apb_write), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_apb_addr", apb_addr, 32'd0);
        chk("rst_apb_wdata", apb_wdata, 32'd0);
        rst = 1'b0;

        // Read 0x104, zero wait states: response 3 cycles after accept
        apb_ready = 1'b1;
        apb_rdata = 32'hA5;
        cmd_write = 1'b0;
        cmd_addr  = 32'h104;
        cmd_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h000000A5, err: 1'b0});
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("rd_setup", {29'd0, apb_sel, apb_en, busy}, 32'b101);
        chk("rd_setup_addr", apb_addr, 32'h104);
        chk("rd_setup_write", 32'(apb_write), 32'd0);
        chk("rd_setup_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("rd_access", {30'd0, apb_sel, apb_en}, 32'b11);
        tick();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
        chk("rd_rsp_rdata", rsp_rdata, 32'hA5);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        chk("rd_back_idle", {30'd0, cmd_ready, rsp_valid}, 32'b10);

        // Non-posted write with 4 wait states
        apb_ready  = 1'b0;
        cmd_write  = 1'b1;
        cmd_posted = 1'b0;
        cmd_addr   = 32'h128;
        cmd_wdata  = 32'h64;
        cmd_valid  = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        chk("wr_setup", {30'd0, apb_sel, apb_en}, 32'b10);
        chk("wr_setup_write", 32'(apb_write), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_access%0d", i),
                {30'd0, apb_sel, apb_en}, 32'b11);
            chk($sformatf("wr_addr%0d", i), apb_addr, 32'h128);
            chk($sformatf("wr_wdata%0d", i), apb_wdata, 32'h64);
            if (i == 4) apb_ready = 1'b1;
            tick();
        end
        apb_ready = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Read timeout: 16 ACCESS cycles, then error response
        apb_rdata = 32'hDEAD_BEEF;
        cmd_write = 1'b0;
        cmd_addr  = 32'h200;
        cmd_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_access%0d", i),
                {29'd0, apb_sel, apb_en, rsp_valid}, 32'b110);
            tick();
        end
        chk("to_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        tick();

        // Response back-pressure
        apb_ready = 1'b1;
        apb_rdata = 32'h5A5A;
        rsp_ready = 1'b0;
        cmd_addr  = 32'h10C;
        cmd_valid = 1'b1;
        exp_q.push_back('{rdata: 32'h5A5A, err: 1'b0});
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            apb_rdata = 32'h1111 * (i + 1);
            chk($sformatf("bp_valid%0d", i),
                {30'd0, rsp_valid, cmd_ready}, 32'b10);
            chk($sformatf("bp_rdata%0d", i), rsp_rdata, 32'h5A5A);
            chk($sformatf("bp_err%0d", i), 32'(rsp_err), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("bp_last_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("bp_after_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);

        // Back-to-back posted writes to 0x108
        cmd_write  = 1'b1;
        cmd_posted = 1'b1;
        cmd_addr   = 32'h108;
        cmd_wdata  = 32'h0AB;
        cmd_valid  = 1'b1;
        tick();
        chk("pw1_setup", {30'd0, apb_sel, apb_en}, 32'b10);
        chk("pw1_wdata", apb_wdata, 32'h0AB);
        cmd_wdata = 32'h1CD;
        tick();
        chk("pw1_access", {29'd0, apb_sel, apb_en, rsp_valid}, 32'b110);
        chk("pw1_access_wdata", apb_wdata, 32'h0AB);
        tick();
        chk("pw_gap", {29'd0, cmd_ready, rsp_valid, apb_sel}, 32'b100);
        tick();
        cmd_valid = 1'b0;
        chk("pw2_setup", {30'd0, apb_sel, apb_en}, 32'b10);
        chk("pw2_wdata", apb_wdata, 32'h1CD);
        tick();
        chk("pw2_access", {29'd0, apb_sel, apb_en, rsp_valid}, 32'b110);
        tick();
        chk("pw_done", {29'd0, busy, rsp_valid, apb_sel}, 32'd0);
        chk("pw_hold_addr", apb_addr, 32'h108);
        chk("pw_hold_wdata", apb_wdata, 32'h1CD);
        cmd_posted = 1'b0;

        // Reset in the middle of ACCESS
        apb_ready = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h300;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mr_in_access", {30'd0, apb_sel, apb_en}, 32'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
        chk("mr_busy_ready", {30'd0, busy, cmd_ready}, 32'b01);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        apb_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("mr_no_rsp%0d", i),
                {30'd0, rsp_valid, busy}, 32'd0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
